// File: rtl/lgn_pkg.sv
// ---------------------------------------------------------------------------
// lgn_pkg
// Shared constants and types for the LGN class reader slice.
//   CLASSES : number of output classes scanned by the reader
//   N       : gate outputs per class (popcount group width)
//   SCORE_W : score width, 2**SCORE_W > N so a full group never overflows
//   CLASS_W : class index width, 2**CLASS_W >= CLASSES
// ---------------------------------------------------------------------------
package lgn_pkg;

   localparam int CLASSES = 10;
   localparam int N       = 15;
   localparam int SCORE_W = 4;
   localparam int CLASS_W = 4;

   // Index of the final class; the scan leaves SCAN after this one
   localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(CLASSES - 1);

   typedef logic [SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lgn_popcount.sv
// ---------------------------------------------------------------------------
// lgn_popcount
// Combinational popcount of one class group. A single instance is shared by
// the whole scan, with the group selected upstream by the scan index.
//   i_bits  : WIDTH gate outputs of one class
//   o_count : number of ones in i_bits, zero-extended to OUT_W bits
// ---------------------------------------------------------------------------
module lgn_popcount
   import lgn_pkg::*;
#(
   parameter int WIDTH = N,
   parameter int OUT_W = SCORE_W
)
(
   input  logic [WIDTH-1:0] i_bits,
   output logic [OUT_W-1:0] o_count
);

   // Plain adder chain; synthesis rebalances it into a tree
   always_comb begin
      o_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_count = o_count + OUT_W'(i_bits[i]);
      end
   end

endmodule

// File: rtl/lgn_class_reader.sv
// ---------------------------------------------------------------------------
// lgn_class_reader
// Consumer end of the LGN output bus. On an accepted start the flat gate
// vector is snapshotted, then one class per cycle is popcounted and the
// argmax tracked. Results are held until the next accepted start.
// Optional build macro: LGN_READER_MARGIN_EN (runner-up tracking, margin out).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   y_in         : gate outputs, class c at [c*N +: N]
//   start        : classification request, honoured only in IDLE
//   busy         : high while scanning
//   done         : one-cycle pulse when results become valid
//   result_valid : results held and valid
//   class_out    : winning class index
//   best_score   : popcount of the winning class
//   margin       : best minus runner-up (0 when the macro is undefined)
//   sel          : class index for the score readout
//   sel_score    : stored score of class sel (0 when sel is out of range)
// ---------------------------------------------------------------------------
module lgn_class_reader
   import lgn_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CLASSES*N-1:0]   y_in,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   result_valid,
   output logic [CLASS_W-1:0]     class_out,
   output logic [SCORE_W-1:0]     best_score,
   output logic [SCORE_W-1:0]     margin,
   input  logic [CLASS_W-1:0]     sel,
   output logic [SCORE_W-1:0]     sel_score
);

   state_t                r_state;
   state_t                w_nextState;
   logic [CLASSES*N-1:0]  r_snap;
   logic [CLASS_W-1:0]    r_idx;
   score_t                r_best;
   logic [CLASS_W-1:0]    r_class;
   score_t                r_score [CLASSES];
   logic                  r_done;
   logic                  r_valid;
   logic [CLASS_W-1:0]    r_classOut;
   score_t                r_bestScore;
   logic [N-1:0]          w_slice;
   score_t                w_score;
   logic                  w_take;
   score_t                w_selScore;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: start is only looked at in IDLE, so re-pulses during
   // SCAN or DONE are dropped rather than queued
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = SCAN;
         SCAN:    if (r_idx == LAST_IDX) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Select the group currently being scanned; a compare-per-class mux keeps
   // the select in range for every idx encoding
   always_comb begin
      w_slice = '0;
      for (int c = 0; c < CLASSES; c++) begin
         if (r_idx == CLASS_W'(c)) w_slice = r_snap[c*N +: N];
      end
   end

   lgn_popcount #(.WIDTH(N), .OUT_W(SCORE_W)) u_popcount (
      .i_bits  (w_slice),
      .o_count (w_score)
   );

   // Strict greater-than means an equal later score never displaces the
   // earlier class, so ties resolve to the lowest index
   assign w_take = (r_idx == '0) || (w_score > r_best);

   // Scan datapath and held results. Scores are cleared on an accepted start
   // so classes not yet reached read back as zero during the scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap      <= '0;
         r_idx       <= '0;
         r_best      <= '0;
         r_class     <= '0;
         r_done      <= 1'b0;
         r_valid     <= 1'b0;
         r_classOut  <= '0;
         r_bestScore <= '0;
         for (int c = 0; c < CLASSES; c++) r_score[c] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_snap  <= y_in;
                  r_idx   <= '0;
                  r_best  <= '0;
                  r_class <= '0;
                  r_valid <= 1'b0;
                  for (int c = 0; c < CLASSES; c++) r_score[c] <= '0;
               end
            end
            SCAN: begin
               for (int c = 0; c < CLASSES; c++) begin
                  if (r_idx == CLASS_W'(c)) r_score[c] <= w_score;
               end
               if (w_take) begin
                  r_best  <= w_score;
                  r_class <= r_idx;
               end
               if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            end
            DONE: begin
               r_done      <= 1'b1;
               r_valid     <= 1'b1;
               r_classOut  <= r_class;
               r_bestScore <= r_best;
            end
            default: ;
         endcase
      end
   end

`ifdef LGN_READER_MARGIN_EN
   score_t r_second;
   score_t r_margin;

   // Runner-up tracking. At idx 1 the best is always class 0, so whatever
   // class 1 scores, the smaller of the two becomes the runner-up. A score
   // equal to best lands in second, giving margin 0 on ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_second <= '0;
         r_margin <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) r_second <= '0;
            SCAN: begin
               if (r_idx == '0) begin
                  r_second <= '0;
               end else if (w_score > r_best) begin
                  r_second <= r_best;
               end else if ((w_score > r_second) || (r_idx == CLASS_W'(1))) begin
                  r_second <= w_score;
               end
            end
            DONE: r_margin <= r_best - r_second;
            default: ;
         endcase
      end
   end

   assign margin = r_margin;
`else
   assign margin = '0;
`endif

   // Score readout; indices past the last class fall through to zero
   always_comb begin
      w_selScore = '0;
      for (int c = 0; c < CLASSES; c++) begin
         if (sel == CLASS_W'(c)) w_selScore = r_score[c];
      end
   end

   assign busy         = (r_state == SCAN);
   assign done         = r_done;
   assign result_valid = r_valid;
   assign class_out    = r_classOut;
   assign best_score   = r_bestScore;
   assign sel_score    = w_selScore;

endmodule

// File: doc/lgn_class_reader.md
Name: lgn_class_reader

Overview:
- Consumer end of the logic-gate-network (LGN) output bus.
- Snapshots the flat gate-output vector, popcounts each class's group of N bits one class per cycle, and tracks the argmax.
- Presents the winning class, its score, and a per-class score readout port to the top-level pin mux.
- Replaces the combinational per-class summation with a small sequential scanner, so only one popcount tree exists in silicon.

Parameters:
- CLASSES, 10, number of output classes.
- N, 15, gate outputs per class (group width).
- SCORE_W, 4, score width; must satisfy 2^SCORE_W > N.
- CLASS_W, 4, class index width; must satisfy 2^CLASS_W >= CLASSES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- y_in  in  CLASSES*N  gate-network outputs; class c occupies bits [c*N +: N].
- start  in  1  request a classification; accepted only in IDLE.
- busy  out  1  high while the scan is in progress (SCAN state).
- done  out  1  one-cycle pulse when results become valid.
- result_valid  out  1  results are held and valid; cleared on the next accepted start.
- class_out  out  CLASS_W  argmax class index.
- best_score  out  SCORE_W  popcount of the winning class.
- margin  out  SCORE_W  best minus runner-up score (see Optional Feature).
- sel  in  CLASS_W  class index for the score readout.
- sel_score  out  SCORE_W  stored score of class sel.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; busy, done, result_valid, class_out, best_score, margin = 0; all per-class score registers = 0.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at a rising edge:
  - Capture y_in into the snapshot register.
  - idx := 0, best := 0, class := 0; clear result_valid.
  - Go to SCAN.
- IDLE, start=0: hold all outputs.
- SCAN, each cycle:
  - s = popcount(snapshot[idx*N +: N]); write s to score[idx].
  - If idx==0 or s > best: best := s, class := idx. The compare is strict, so on a tie the lowest index wins.
  - If idx==CLASSES-1, go to DONE; otherwise idx+1.
- DONE, for one cycle:
  - done=1, result_valid:=1, class_out/best_score/margin registered from the scan state.
  - Next state is IDLE.
- Latency: start accepted at edge T → done high in the cycle after edge T+CLASSES+1 (i.e. 11 edges later for CLASSES=10). Throughput is one classification per CLASSES+2 cycles.
- start is ignored in SCAN and DONE; there is no queueing.
- y_in changes after the capture edge have no effect on the current result.
- sel_score is combinational from score[sel]. For sel >= CLASSES it returns 0. Scores of classes not yet scanned read 0 during SCAN.
- Outputs hold their last values in IDLE until the next accepted start.
- Reset asserted mid-scan: immediate return to reset values; no done pulse.
- Widths: popcount is zero-extended into SCORE_W; no overflow is possible given the SCORE_W constraint.

Optional Feature:
- Macro LGN_READER_MARGIN_EN.
- Defined:
  - Also tracks the runner-up score.
  - When s > best: second := best.
  - Else if s > second (or idx==1 and class 0 holds best): second := s.
  - margin = best - second, registered in DONE.
  - All-equal scores give margin 0.
- Undefined: margin is tied to 0 and no runner-up register is built.

Decomposition:
- Package lgn_pkg holds:
  - CLASSES, N, SCORE_W, CLASS_W constants.
  - State enum {IDLE, SCAN, DONE}.
  - Score typedef logic [SCORE_W-1:0].
- One sub-module, lgn_popcount: combinational N-bit popcount producing SCORE_W bits, instantiated once and muxed by idx.

Test Plan:
- y_in all zero, start pulse → done 11 cycles later; class_out=0, best_score=0, margin=0 (macro on); sel_score=0 for every sel.
- Class 7 slice = 15'h7FFF, every other class = 15'h0007 → class_out=7, best_score=15, margin=12; sel=3 gives sel_score=3.
- Classes 2 and 5 both 15'h01FF (9), all others 4 → class_out=2 (tie goes to lowest), best_score=9, margin=0.
- During SCAN: start re-pulsed and y_in flipped to all ones → ignored; result matches the original snapshot; busy is high for exactly 10 cycles.
- rst_n pulled low at scan idx=4 → busy, result_valid, class_out and scores are 0 immediately; no done pulse. A new start after release yields correct results.
- sel=12 (out of range) → sel_score=0. Build without the macro → margin stays 0 for the class-7 vector.
